time_display_driver: RTL and testbench
======================================

# time_display_driver

Downstream consumer of the seconds/minutes counter. Samples the binary `second` and `minute` values and converts each to two BCD digits with a sequential shift-add-3 engine. Drives a 4-digit time-multiplexed 7-segment display with a programmable scan rate. Sits between the counter stage and the board display pins.

## Interface
- `SCAN_DIV`, default 4: clocks each digit stays selected; legal values are ≥2.
- `SEG_ACTIVE_LOW`, default 0: when 1, `seg` and `dig_sel` are inverted at the output.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; one clock, synchronous reset, active-high.
- `second`  in  6  binary seconds from the counter; range 0..63 accepted, 0..60 expected.
- `minute`  in  6  binary minutes from the counter; range 0..63 accepted.
- `seg`  out  7  segment pattern, bit order {g,f,e,d,c,b,a}, active-high before the polarity option is applied.
- `dig_sel`  out  4  one-hot digit enable: bit0 = second units, bit1 = second tens, bit2 = minute units, bit3 = minute tens.
- `busy`  out  1  high while a conversion is in flight (states CONV and LOAD).
- `done`  out  1  one-cycle pulse in the LOAD cycle; the display digits update at the end of this cycle.

## Operation
- Snapshot registers `snap_s`/`snap_m` (6b each) hold the last accepted input values. Displayed digit registers are `d0..d3` (4b each).
- FSM states:
  - IDLE: if `{second,minute} != {snap_s,snap_m}`, latch both inputs into the snapshots, load the shift registers, clear the iteration counter, and go to CONV. Otherwise stay in IDLE.
  - CONV: runs 6 iterations, one per clock. Both values are converted in parallel.
  - Each iteration: every BCD nibble ≥5 first gets +3, then the {bcd,bin} register shifts left by 1.
  - After the 6th iteration, go to LOAD.
  - LOAD: write the BCD results to `d0..d3`, assert `done`, return to IDLE.
- Input changes during CONV or LOAD are ignored. The next IDLE cycle compares against the snapshot, so the final stable input is always displayed. Intermediate values may be skipped.
- The 6-bit input gives at most 63, so each tens digit is ≤6 and each units digit is ≤9. No overflow path exists.
- Scan logic runs independently of the FSM, including during conversion:
  - The divider counts 0..SCAN_DIV-1.
  - On terminal count, the digit index advances 0→1→2→3→0.
  - `seg` is the combinational decode of the currently selected `d`.
- Decode patterns, active-high, in gfedcba order: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Nibbles 10..15 decode to 0000000; these are unreachable.
- Reset values (before polarity inversion):
  - state IDLE, snapshots 0, `d0..d3` = 0, divider 0, digit index 0.
  - outputs: `dig_sel`=0001, `seg`=0111111, `busy`=0, `done`=0.
- Reset asserted mid-CONV/LOAD aborts the conversion. Digits return to 0000 and no `done` is emitted.

## Timing
- Call the edge on which IDLE detects a difference E0. At E0 the snapshot latches and the FSM enters CONV.
- E1..E6 perform the 6 iterations; E6 moves the FSM to LOAD.
- `done` is high in the cycle between E6 and E7. At E7, `d0..d3` take the new values and the FSM returns to IDLE.
- Latency from the sampling edge to updated digits is 7 clocks.
- `busy` is high from after E0 until E7.
- The earliest next sample is at E8, giving a throughput of 1 conversion per 8 clocks.
- A digit is selected for exactly SCAN_DIV clocks. A full refresh takes 4×SCAN_DIV clocks.
- `dig_sel` and the digit index change together, so there is no cycle with a mismatched `seg`.

## Structure
- Shared package `time_disp_pkg` holds:
  - the FSM state enum {IDLE, CONV, LOAD};
  - the 10 segment pattern constants plus SEG_BLANK;
  - the iteration count constant (6).
- One sub-module, `seg7_decode`: a purely combinational 4b→7b lookup using the package constants.

## Test plan
- Reset with inputs at 0 → `dig_sel`=0001, `seg`=0111111, `busy`=0. No conversion follows, because inputs equal the snapshot.
- Drive second=45, minute=7 → `busy` high for 7 clocks, then a single `done` pulse. `d0..d3` = 5,4,7,0. While `dig_sel`=0001, `seg`=1101101.
- Drive second=60, minute=60 → digits 0,6,0,6. The tens digits show 1111101 on the bit1 and bit3 selects.
- With SCAN_DIV=4, hold inputs and observe 16 clocks → `dig_sel` sequence 0001,0010,0100,1000, each held exactly 4 clocks, then the sequence repeats.
- Change second 10→11 two clocks after E0 → the first conversion shows 10. `done` pulses, and at E8 a second conversion starts and ends showing 11.
- Assert `rst` at E3 of a 59/59 conversion → the next clock shows digits 0000, `busy`=0, and no `done`. After release with inputs at 59/59, a fresh conversion yields 9,5,9,5.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared types and constants for the time display driver.
// FSM states, segment patterns, iteration count, shift-add-3 step.
package time_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_e;

  // gfedcba, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int ITERS = 6;

  // One double-dabble iteration on {tens,units,bin[5:0]}
  function automatic logic [13:0] dd_step(
    input logic [13:0] r
  );
    logic [13:0] t;
    t = r;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to 7-segment pattern (gfedcba, active-high).
// bcd_i: 4b digit; seg_o: 7b pattern, blank for 10..15.
module seg7_decode
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_display_driver.sv
// mm:ss binary-to-BCD converter driving a 4-digit muxed 7-seg display.
// Ports: clk, rst, second, minute in; seg, dig_sel, busy, done out.
module time_display_driver
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       busy,
  output logic       done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  state_e            state_q, state_d;
  logic [5:0]        snap_s_q, snap_s_d;
  logic [5:0]        snap_m_q, snap_m_d;
  logic [13:0]       sh_s_q, sh_s_d;
  logic [13:0]       sh_m_q, sh_m_d;
  logic [2:0]        iter_q, iter_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic [DW-1:0]     div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_raw;
  logic              tc;

  always_comb begin
    state_d  = state_q;
    snap_s_d = snap_s_q;
    snap_m_d = snap_m_q;
    sh_s_d   = sh_s_q;
    sh_m_d   = sh_m_q;
    iter_d   = iter_q;
    dig_d    = dig_q;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ({second, minute} != {snap_s_q, snap_m_q}) begin
          snap_s_d = second;
          snap_m_d = minute;
          sh_s_d   = {8'd0, second};
          sh_m_d   = {8'd0, minute};
          iter_d   = 3'd0;
          state_d  = CONV;
        end
      end
      CONV: begin
        sh_s_d = dd_step(sh_s_q);
        sh_m_d = dd_step(sh_m_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(ITERS - 1)) state_d = LOAD;
      end
      LOAD: begin
        dig_d   = {sh_m_q[13:10], sh_m_q[9:6],
                   sh_s_q[13:10], sh_s_q[9:6]};
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Scan runs free of the FSM
  assign tc    = (div_q == DIV_LAST);
  assign div_d = tc ? '0 : div_q + 1'b1;
  assign idx_d = tc ? idx_q + 2'd1 : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      snap_s_q <= '0;
      snap_m_q <= '0;
      sh_s_q   <= '0;
      sh_m_q   <= '0;
      iter_q   <= '0;
      dig_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      snap_s_q <= snap_s_d;
      snap_m_q <= snap_m_d;
      sh_s_q   <= sh_s_d;
      sh_m_q   <= sh_m_d;
      iter_q   <= iter_d;
      dig_q    <= dig_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
    end
  end

  seg7_decode u_dec (
    .bcd_i (dig_q[idx_q]),
    .seg_o (seg_raw)
  );

  assign seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign dig_sel = SEG_ACTIVE_LOW ? ~(4'b0001 << idx_q)
                                  : (4'b0001 << idx_q);

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver.
// Table vectors, hand sequences and random values vs a model.
module tb_time_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] second = '0;
  logic [5:0] minute = '0;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;
  int tick   = 0;

  logic [6:0] pat [10];

  typedef struct {
    logic [5:0]  s;
    logic [5:0]  m;
    logic [15:0] dg;
  } vec_t;

  vec_t tbl [7];

  time_display_driver #(
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .second  (second),
    .minute  (minute),
    .seg     (seg),
    .dig_sel (dig_sel),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Count of non-reset edges since last reset: gives scan position
  always @(posedge clk) begin
    if (rst) tick <= 0;
    else     tick <= tick + 1;
  end

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      passed++;
  endtask

  function automatic logic [15:0] model(input int s, input int m);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_disp(input logic [15:0] dg);
    int k;
    logic [3:0] d;
    k = (tick / SD) % 4;
    d = dg[k*4 +: 4];
    check("dig_sel", int'(dig_sel), 1 << k);
    check("seg", int'(seg), int'(pat[d]));
  endtask

  task automatic scan_check(input int n, input logic [15:0] dg);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_disp(dg);
    end
  endtask

  task automatic wait_conv(output int bc, output int dc,
                           output int dat);
    bc = 0; dc = 0; dat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (done) begin dc++; dat = bc; end
    end
    check("done_idle", int'(done), 0);
  endtask

  task automatic run_conv(input int s, input int m);
    int bc, dc, dat;
    second = 6'(s);
    minute = 6'(m);
    wait_conv(bc, dc, dat);
    check("busy_len", bc, 7);
    check("done_cnt", dc, 1);
    check("done_pos", dat, 7);
  endtask

  initial begin
    int bc, dc, dat, ls, lm, s, m;
    pat[0] = 7'b0111111; pat[1] = 7'b0000110;
    pat[2] = 7'b1011011; pat[3] = 7'b1001111;
    pat[4] = 7'b1100110; pat[5] = 7'b1101101;
    pat[6] = 7'b1111101; pat[7] = 7'b0000111;
    pat[8] = 7'b1111111; pat[9] = 7'b1101111;
    tbl[0] = '{6'd45, 6'd7,  16'h0745};
    tbl[1] = '{6'd60, 6'd60, 16'h6060};
    tbl[2] = '{6'd59, 6'd59, 16'h5959};
    tbl[3] = '{6'd63, 6'd63, 16'h6363};
    tbl[4] = '{6'd9,  6'd10, 16'h1009};
    tbl[5] = '{6'd1,  6'd0,  16'h0001};
    tbl[6] = '{6'd0,  6'd0,  16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dig_sel", int'(dig_sel), 1);
    check("rst_seg", int'(seg), int'(7'b0111111));
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    check_disp(16'h0000);
    // Idle scan: 0001,0010,0100,1000 each SD clocks, then repeat
    scan_check(4 * SD + 3, 16'h0000);
    check("idle_busy", int'(busy), 0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_conv(int'(tbl[i].s), int'(tbl[i].m));
      scan_check(4 * SD, tbl[i].dg);
    end

    // Input change two clocks after E0 is deferred
    second = 6'd10;
    minute = 6'd5;
    repeat (2) @(negedge clk);
    check("ovl_busy_early", int'(busy), 1);
    second = 6'd11;
    bc = 2; dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (done) dc++;
    end
    check("ovl_busy_len", bc, 7);
    check("ovl_done_cnt", dc, 1);
    check_disp(model(10, 5));
    wait_conv(bc, dc, dat);
    check("ovl2_busy_len", bc, 7);
    check("ovl2_done_cnt", dc, 1);
    scan_check(4 * SD, model(11, 5));
    ls = 11; lm = 5;

    // Random values against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      s = int'($urandom_range(0, 63));
      m = int'($urandom_range(0, 63));
      if (s == ls && m == lm) s = (s + 1) % 64;
      run_conv(s, m);
      scan_check(4 * SD, model(s, m));
      ls = s; lm = m;
    end

    // Reset in the middle of a conversion
    run_conv(12, 34);
    scan_check(4 * SD, model(12, 34));
    second = 6'd59;
    minute = 6'd59;
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dc++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done) dc++;
    check("abort_done", dc, 0);
    check("abort_busy", int'(busy), 0);
    check("abort_dig_sel", int'(dig_sel), 1);
    check("abort_seg", int'(seg), int'(pat[0]));
    rst = 1'b0;
    wait_conv(bc, dc, dat);
    check("post_busy_len", bc, 7);
    check("post_done_cnt", dc, 1);
    scan_check(4 * SD, model(59, 59));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
